traffic_phase_ctrl: RTL and testbench

- Main/side intersection sequencer that drives a 4-bit countdown timer block.
- On each phase entry it loads the phase duration and starts the timer; it advances when the timer's `expired` pulse arrives.
- Inputs: side-street vehicle sensor and pedestrian walk button. Outputs: lamp drives for both roads and the walk lamp.
- Sits between the board I/O and the timer/divider chain.

---
 rtl/traffic_phase_ctrl.sv | 131 +++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: main/side intersection sequencer driving a countdown timer; `NIGHT_FLASH_EN adds a night flashing mode
module traffic_phase_ctrl #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2,
  parameter logic [3:0] T_WALK = 4'd4
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       sensor,
  input  logic       walk_request,
`ifdef NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] timer_value,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_lamp,
  output logic [2:0] phase
);
  localparam logic [3:0] D_BASE = (T_BASE == 4'd0) ? 4'd1 : T_BASE;
  localparam logic [3:0] D_EXT  = (T_EXT  == 4'd0) ? 4'd1 : T_EXT;
  localparam logic [3:0] D_YEL  = (T_YEL  == 4'd0) ? 4'd1 : T_YEL;
  localparam logic [3:0] D_WALK = (T_WALK == 4'd0) ? 4'd1 : T_WALK;
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    WALK        = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_EXT    = 3'd4,
`ifdef NIGHT_FLASH_EN
    FLASH       = 3'd6,
`endif
    SIDE_YELLOW = 3'd5
  } state_t;
  state_t state, nxt;
  logic [1:0] sensor_q, walk_q;
  logic sensor_s, walk_s, night_s, armed, load_req, walk_pending, take;
  logic [2:0] main_nxt, side_nxt;
  logic [3:0] dur_nxt;
  assign sensor_s = sensor_q[1];
  assign walk_s = walk_q[1];
  assign take = armed & expired;
  assign phase = state;
`ifdef NIGHT_FLASH_EN
  logic [1:0] night_q;
  logic flash_on, flash_nxt;
  assign night_s = night_q[1];
  // night_mode synchroniser and the flashing on/off half of the FLASH phase
  always_ff @(posedge clk or posedge sys_reset)
    if (sys_reset) begin
      night_q <= '0;
      flash_on <= 1'b0;
    end else begin
      night_q <= {night_q[0], night_mode};
      flash_on <= flash_nxt;
    end
`else
  assign night_s = 1'b0;
`endif
  // two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk or posedge sys_reset)
    if (sys_reset) begin
      sensor_q <= '0;
      walk_q <= '0;
    end else begin
      sensor_q <= {sensor_q[0], sensor};
      walk_q <= {walk_q[0], walk_request};
    end
  // phase register
  always_ff @(posedge clk or posedge sys_reset)
    if (sys_reset) state <= MAIN_GREEN;
    else state <= nxt;
  // next phase, only on an armed expiry; an idle MAIN_GREEN expiry re-enters itself to reload the timer
  always_comb begin
    nxt = state;
    if (take)
      case (state)
        MAIN_GREEN:  nxt = (sensor_s || walk_pending || night_s) ? MAIN_YELLOW : MAIN_GREEN;
`ifdef NIGHT_FLASH_EN
        MAIN_YELLOW: nxt = night_s ? FLASH : walk_pending ? WALK : SIDE_GREEN;
        FLASH:       nxt = night_s ? FLASH : MAIN_GREEN;
`else
        MAIN_YELLOW: nxt = walk_pending ? WALK : SIDE_GREEN;
`endif
        WALK:        nxt = sensor_s ? SIDE_GREEN : MAIN_GREEN;
        SIDE_GREEN:  nxt = sensor_s ? SIDE_EXT : SIDE_YELLOW;
        SIDE_EXT:    nxt = SIDE_YELLOW;
        SIDE_YELLOW: nxt = MAIN_GREEN;
        default:     nxt = MAIN_GREEN;
      endcase
  end
  // lamps and load value of the phase being entered; registered below so the lamp drives never glitch
  always_comb begin
    main_nxt = (nxt == MAIN_GREEN) ? 3'b001 : (nxt == MAIN_YELLOW) ? 3'b010 : 3'b100;
    side_nxt = (nxt == SIDE_GREEN || nxt == SIDE_EXT) ? 3'b001 : (nxt == SIDE_YELLOW) ? 3'b010 : 3'b100;
    dur_nxt = (nxt == MAIN_YELLOW || nxt == SIDE_YELLOW) ? D_YEL : (nxt == WALK) ? D_WALK :
              (nxt == SIDE_EXT) ? D_EXT : D_BASE;
`ifdef NIGHT_FLASH_EN
    flash_nxt = (take && nxt == FLASH) ? (state != FLASH || !flash_on) : flash_on;
    if (nxt == FLASH) begin
      main_nxt = flash_nxt ? 3'b010 : 3'b000;
      side_nxt = flash_nxt ? 3'b100 : 3'b000;
      dur_nxt = D_YEL;
    end
`endif
  end
  // timer handshake, walk latch and registered lamp outputs
  always_ff @(posedge clk or posedge sys_reset)
    if (sys_reset) begin
      load_req <= 1'b1;
      start_timer <= 1'b0;
      armed <= 1'b0;
      timer_value <= D_BASE;
      main_light <= 3'b001;
      side_light <= 3'b100;
      walk_lamp <= 1'b0;
      walk_pending <= 1'b0;
    end else begin
      load_req <= 1'b0;
      start_timer <= load_req || take;
      armed <= start_timer || (armed && !take);
      timer_value <= dur_nxt;
      main_light <= main_nxt;
      side_light <= side_nxt;
      walk_lamp <= (nxt == WALK);
      walk_pending <= (take && nxt == WALK) ? 1'b0 : (walk_pending || walk_s);
    end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: table-driven directed checks of the intersection sequencer
module tb_traffic_phase_ctrl;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100, O = 3'b000;
  typedef struct {
    logic s, w, e, st;
    logic [3:0] tv;
    logic [2:0] m, sd;
    logic wl;
    logic [2:0] ph;
  } vec_t;
  logic clk = 1'b0, sys_reset = 1'b1, sensor = 1'b0, walk_request = 1'b0, expired = 1'b0;
  logic start_timer, walk_lamp;
  logic [3:0] timer_value;
  logic [2:0] main_light, side_light, phase;
  int checks = 0, errors = 0;
  vec_t vq[$];
`ifdef NIGHT_FLASH_EN
  logic night_mode = 1'b0;
`endif
  traffic_phase_ctrl dut (
    .clk(clk),
    .sys_reset(sys_reset),
    .sensor(sensor),
    .walk_request(walk_request),
`ifdef NIGHT_FLASH_EN
    .night_mode(night_mode),
`endif
    .expired(expired),
    .start_timer(start_timer),
    .timer_value(timer_value),
    .main_light(main_light),
    .side_light(side_light),
    .walk_lamp(walk_lamp),
    .phase(phase)
  );
  always #5 clk = ~clk;
  task add(input logic s, w, e, st, input logic [3:0] tv, input logic [2:0] m, sd, input logic wl, input logic [2:0] ph);
    vq.push_back('{s, w, e, st, tv, m, sd, wl, ph});
  endtask
  task step(input logic s, w, e);
    @(negedge clk);
    sensor = s;
    walk_request = w;
    expired = e;
    @(posedge clk);
    #1;
  endtask
  task chk(input string nm, input logic st, input logic [3:0] tv, input logic ctv, input logic [2:0] m, sd, input logic wl, input logic [2:0] ph);
    checks++;
    if (start_timer !== st || main_light !== m || side_light !== sd || walk_lamp !== wl || phase !== ph || (ctv && timer_value !== tv)) begin
      errors++;
      $display("FAIL %s: got st=%b tv=%0d main=%b side=%b walk=%b ph=%0d, want st=%b tv=%0d main=%b side=%b walk=%b ph=%0d",
               nm, start_timer, timer_value, main_light, side_light, walk_lamp, phase, st, tv, m, sd, wl, ph);
    end
  endtask
  initial begin
    add(0,0,1, 1,6,G,R,0,0); add(0,0,1, 0,0,G,R,0,0); add(0,0,1, 1,6,G,R,0,0); add(0,0,0, 0,0,G,R,0,0);
    add(1,0,0, 0,0,G,R,0,0); add(1,0,0, 0,0,G,R,0,0); add(1,0,1, 1,2,Y,R,0,1); add(1,0,0, 0,0,Y,R,0,1);
    add(1,0,1, 1,6,R,G,0,3); add(1,0,0, 0,0,R,G,0,3); add(1,0,1, 1,3,R,G,0,4); add(0,0,0, 0,0,R,G,0,4);
    add(0,0,1, 1,2,R,Y,0,5); add(0,0,0, 0,0,R,Y,0,5); add(0,0,1, 1,6,G,R,0,0); add(0,1,0, 0,0,G,R,0,0);
    add(0,0,0, 0,0,G,R,0,0); add(0,0,0, 0,0,G,R,0,0); add(0,0,1, 1,2,Y,R,0,1); add(0,0,0, 0,0,Y,R,0,1);
    add(0,0,1, 1,4,R,R,1,2); add(0,0,0, 0,0,R,R,1,2); add(0,0,1, 1,6,G,R,0,0); add(0,0,0, 0,0,G,R,0,0);
    add(0,0,1, 1,6,G,R,0,0); add(0,0,0, 0,0,G,R,0,0); add(1,1,0, 0,0,G,R,0,0); add(1,1,0, 0,0,G,R,0,0);
    add(1,1,1, 1,2,Y,R,0,1); add(1,1,0, 0,0,Y,R,0,1); add(1,1,1, 1,4,R,R,1,2); add(0,1,0, 0,0,R,R,1,2);
    add(0,0,1, 1,6,R,G,0,3); add(0,0,0, 0,0,R,G,0,3); add(0,0,1, 1,2,R,Y,0,5); add(0,0,0, 0,0,R,Y,0,5);
    add(0,0,1, 1,6,G,R,0,0); add(0,0,0, 0,0,G,R,0,0); add(0,0,1, 1,2,Y,R,0,1); add(0,0,0, 0,0,Y,R,0,1);
    add(0,0,1, 1,4,R,R,1,2); add(0,0,0, 0,0,R,R,1,2); add(0,0,1, 1,6,G,R,0,0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 6, 1, G, R, 0, 0);
    sys_reset = 1'b0;
    foreach (vq[i]) begin
      step(vq[i].s, vq[i].w, vq[i].e);
      chk($sformatf("vec%0d", i + 1), vq[i].st, vq[i].tv, vq[i].st, vq[i].m, vq[i].sd, vq[i].wl, vq[i].ph);
    end
    step(1,0,0); step(1,0,0);
    step(1,0,1); chk("to_myel", 1, 2, 1, Y, R, 0, 1);
    step(1,0,0); step(1,0,1); chk("to_sgrn", 1, 6, 1, R, G, 0, 3);
    step(1,0,0); step(1,0,1); chk("to_sext", 1, 3, 1, R, G, 0, 4);
    step(1,0,0); chk("in_sext", 0, 0, 0, R, G, 0, 4);
    #1 sys_reset = 1'b1;
    #1 chk("async_rst", 0, 6, 1, G, R, 0, 0);
    @(posedge clk);
    #1 chk("held_rst", 0, 6, 1, G, R, 0, 0);
    sys_reset = 1'b0;
    step(0,0,0); chk("post_rst", 1, 6, 1, G, R, 0, 0);
    step(0,0,1); chk("post_rst_arm", 0, 0, 0, G, R, 0, 0);
`ifdef NIGHT_FLASH_EN
    night_mode = 1'b1;
    step(0,0,0); step(0,0,0);
    step(0,0,1); chk("night_myel", 1, 2, 1, Y, R, 0, 1);
    step(0,0,0); step(0,0,1); chk("flash_on", 1, 2, 1, Y, R, 0, 6);
    step(0,0,0); step(0,0,1); chk("flash_off", 1, 2, 1, O, O, 0, 6);
    night_mode = 1'b0;
    step(0,0,0); step(0,0,1); chk("flash_on2", 1, 2, 1, Y, R, 0, 6);
    step(0,0,0); step(0,0,1); chk("flash_exit", 1, 6, 1, G, R, 0, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
